// File: rtl/decrypt_iterative.sv
// AES-128 inverse cipher on one shared round datapath; the key schedule is walked forward to k10, then regenerated backwards.
// Latency 20 edges from accept to the outputValid pulse; start is only taken while ready=1, with one block in flight and no queueing.
module decrypt_iterative (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         start,
   input  logic [127:0] inputData,
   input  logic [127:0] inputKey,
   output logic         ready,
   output logic [127:0] outputData,
   output logic         outputValid
);

   typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, FINAL} fsmState;

   fsmState        curState, nxtState;
   logic [127:0]   stateReg, keyReg;
   logic [7:0]     rcon;
   logic [3:0]     cnt;
   logic [127:0]   fwdKey, bwdKey, invSubOut, roundOut, finalOut;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] invXtime(input logic [7:0] a);
      return a[0] ? ({1'b1, a[7:1]} ^ 8'h0d) : {1'b0, a[7:1]};
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gInv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] b;
      logic [7:0] e;
      r = 8'h01;
      b = a;
      e = 8'hfe;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gmul(r, b);
         b = gmul(b, b);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gInv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] invSbox(input logic [7:0] s);
      return gInv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [31:0] subRotWord(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [127:0] keyFwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ subRotWord(k[31:0]) ^ {rc, 24'h0};
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Undo one expansion step: the previous w3 is recovered first because it feeds SubWord.
   function automatic logic [127:0] keyBwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] p0, p1, p2, p3;
      p3 = k[31:0] ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ subRotWord(p3) ^ {rc, 24'h0};
      return {p0, p1, p2, p3};
   endfunction

   // Byte n (0..15) lives at [8*(15-n) +: 8]; row r, column c is byte r+4c.
   function automatic logic [127:0] invShiftSub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[8*(15-(r+4*c)) +: 8] = invSbox(s[8*(15-(r+4*((c+4-r)%4))) +: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] invMixColumns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[8*(15-4*c) +: 8];
         a1 = s[8*(14-4*c) +: 8];
         a2 = s[8*(13-4*c) +: 8];
         a3 = s[8*(12-4*c) +: 8];
         o[8*(15-4*c) +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[8*(14-4*c) +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[8*(13-4*c) +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[8*(12-4*c) +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   assign fwdKey    = keyFwd(keyReg, rcon);
   assign bwdKey    = keyBwd(keyReg, rcon);
   assign invSubOut = invShiftSub(stateReg);
   assign finalOut  = invSubOut ^ bwdKey;
   assign roundOut  = invMixColumns(finalOut);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) curState <= IDLE;
      else        curState <= nxtState;
   end

   always_comb begin
      nxtState = curState;
      case (curState)
         IDLE:    if (start) nxtState = KEYEXP;
         KEYEXP:  if (cnt == 4'd10) nxtState = ROUND;
         ROUND:   if (cnt == 4'd9) nxtState = FINAL;
         FINAL:   nxtState = IDLE;
         default: nxtState = IDLE;
      endcase
   end

   always_comb begin
      ready = (curState == IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stateReg    <= '0;
         keyReg      <= '0;
         rcon        <= 8'h00;
         cnt         <= 4'd0;
         outputData  <= '0;
         outputValid <= 1'b0;
      end else begin
         outputValid <= 1'b0;
         case (curState)
            IDLE: begin
               if (start) begin
                  stateReg <= inputData;
                  keyReg   <= inputKey;
                  rcon     <= 8'h01;
                  cnt      <= 4'd1;
               end
            end
            KEYEXP: begin
               keyReg <= fwdKey;
               // rcon stays at 0x36 after k10 so the backward walk starts from the same constant.
               if (cnt == 4'd10) begin
                  stateReg <= stateReg ^ fwdKey;
                  cnt      <= 4'd1;
               end else begin
                  rcon <= xtime(rcon);
                  cnt  <= cnt + 4'd1;
               end
            end
            ROUND: begin
               keyReg   <= bwdKey;
               stateReg <= roundOut;
               rcon     <= invXtime(rcon);
               cnt      <= cnt + 4'd1;
            end
            FINAL: begin
               outputData  <= finalOut;
               outputValid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_decrypt_iterative.sv
// Directed bench for decrypt_iterative: FIPS-197 vectors, back-to-back, busy-ignore and mid-run reset.
module tb_decrypt_iterative;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic         start = 1'b0;
   logic [127:0] inputData = '0;
   logic [127:0] inputKey = '0;
   logic         ready;
   logic [127:0] outputData;
   logic         outputValid;

   decrypt_iterative dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .inputData(inputData), .inputKey(inputKey),
      .ready(ready), .outputData(outputData), .outputValid(outputValid)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [127:0] data;
      int           edgeNo;
   } expT;

   localparam logic [127:0] C1KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] BKEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] BCT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] BPT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] ZCT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   expT  sb[$];
   expT  mon;
   logic prevValid = 1'b0;
   int   acc;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic checkBit(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic checkInt(input string tag, input int got, input int exp);
      total++;
      assert (got == exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Scoreboard side: every outputValid pulse must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (outputValid === 1'b1) begin
         checkBit("pulseWidth", prevValid, 1'b0);
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL spuriousValid got=pulse exp=none data=%h", outputData);
         end
         if (sb.size() != 0) begin
            mon = sb.pop_front();
            check("plaintext", outputData, mon.data);
            checkInt("latency", cyc - mon.edgeNo, 20);
         end
      end
      prevValid = outputValid;
   end

   // Called at a negedge while idle; returns at the negedge after the accept edge.
   task automatic startOp(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt, output int accEdge);
      checkBit("readyBeforeStart", ready, 1'b1);
      inputData = ct;
      inputKey  = key;
      start     = 1'b1;
      accEdge   = cyc + 1;
      sb.push_back('{pt, cyc + 1});
      @(negedge CLK);
      start     = 1'b0;
      inputData = {$urandom, $urandom, $urandom, $urandom};
      inputKey  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic waitDone(input int maxCyc);
      int n;
      n = 0;
      while (sb.size() != 0 && n < maxCyc) begin
         @(negedge CLK);
         n++;
      end
      checkInt("outstanding", sb.size(), 0);
      @(negedge CLK);
   endtask

   task automatic waitEdge(input int e);
      while (cyc < e) @(negedge CLK);
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      checkBit("rstReady", ready, 1'b1);
      checkBit("rstValid", outputValid, 1'b0);
      check("rstData", outputData, '0);
      RST_N = 1'b1;
      @(negedge CLK);

      // C.1 with ready tracked on every cycle of the operation
      startOp(C1CT, C1KEY, C1PT, acc);
      for (int i = 0; i < 20; i++) begin
         checkBit("busyReady", ready, 1'b0);
         @(negedge CLK);
      end
      checkBit("doneReady", ready, 1'b1);
      checkBit("doneValid", outputValid, 1'b1);
      repeat (3) @(negedge CLK);
      check("holdData", outputData, C1PT);
      checkBit("validLow", outputValid, 1'b0);

      startOp(BCT, BKEY, BPT, acc);
      waitDone(40);
      startOp(ZCT, 128'h0, 128'h0, acc);
      waitDone(40);

      // Back-to-back with start held high
      inputData = C1CT;
      inputKey  = C1KEY;
      start     = 1'b1;
      acc       = cyc + 1;
      sb.push_back('{C1PT, acc});
      sb.push_back('{BPT, acc + 21});
      @(negedge CLK);
      checkBit("b2bBusy", ready, 1'b0);
      inputData = BCT;
      inputKey  = BKEY;
      waitEdge(acc + 20);
      checkBit("b2bValid1", outputValid, 1'b1);
      checkBit("b2bReadyAtValid", ready, 1'b1);
      @(negedge CLK);
      checkBit("b2bSecondAccept", ready, 1'b0);
      checkBit("b2bValidCleared", outputValid, 1'b0);
      check("b2bDataUndisturbed", outputData, C1PT);
      start = 1'b0;
      waitDone(45);
      check("b2bFinalData", outputData, BPT);

      // Busy-ignore: garbage start pulses before E5 and E15
      startOp(C1CT, C1KEY, C1PT, acc);
      waitEdge(acc + 4);
      start     = 1'b1;
      inputData = {$urandom, $urandom, $urandom, $urandom};
      inputKey  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge CLK);
      start = 1'b0;
      waitEdge(acc + 14);
      start     = 1'b1;
      inputData = {$urandom, $urandom, $urandom, $urandom};
      @(negedge CLK);
      start = 1'b0;
      checkBit("ignoreBusy", ready, 1'b0);
      waitDone(40);
      repeat (25) @(negedge CLK);
      check("ignoreData", outputData, C1PT);

      // Reset mid-run, asynchronously after E12
      startOp(C1CT, C1KEY, C1PT, acc);
      waitEdge(acc + 11);
      @(posedge CLK);
      #2;
      sb.delete();
      RST_N = 1'b0;
      #1;
      checkBit("abortReady", ready, 1'b1);
      checkBit("abortValid", outputValid, 1'b0);
      check("abortData", outputData, '0);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (30) @(negedge CLK);
      check("abortQuiet", outputData, '0);
      startOp(C1CT, C1KEY, C1PT, acc);
      waitDone(40);
      check("afterAbort", outputData, C1PT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog got=timeout exp=finish total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
